// File: rtl/mem_resp.sv
// Memory responder: serialises strobed operand reads and one result write
// through a single-port RAM with wait states, stalling the control unit meanwhile.
module mem_resp #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned WAIT   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memWE,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              mem1RE,
  input  logic              mem2RE,
  input  logic              mem3RE,
  input  logic              mem4RE,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [ADDR_W-1:0] addr2,
  input  logic [ADDR_W-1:0] addr3,
  input  logic [ADDR_W-1:0] addr4,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  output logic [DATA_W-1:0] rdata3,
  output logic [DATA_W-1:0] rdata4,
  output logic              stall,
  output logic              busy
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned SLOTS  = 4;
  localparam int unsigned PEND_W = SLOTS + 1;
  localparam int unsigned DEPTH  = 2 ** ADDR_W;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t                        state, state_next;
  logic [PEND_W-1:0]             pend;
  logic [PEND_W-1:0]             cur;
  logic [CNT_W-1:0]              cnt;
  logic [SLOTS-1:0][ADDR_W-1:0]  addr_q;
  logic [ADDR_W-1:0]             waddr_q;
  logic [DATA_W-1:0]             wdata_q;
  logic [SLOTS-1:0][DATA_W-1:0]  rdata_q;
  logic                          busy_q;
  logic                          req;
  logic                          capture;
  logic                          complete;
  logic                          last;
  logic                          ram_we;

  logic [DATA_W-1:0] ram [DEPTH];

  // Lowest pending bit wins: reads R1..R4 first, write (bit 4) last.
  assign cur    = pend & (~pend + PEND_W'(1));
  assign last   = (pend & ~cur) == '0;
  assign req    = memWE | mem1RE | mem2RE | mem3RE | mem4RE;
  assign ram_we = complete & cur[SLOTS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    stall      = 1'b0;
    capture    = 1'b0;
    complete   = 1'b0;
    case (state)
      IDLE: begin
        stall   = req;
        capture = req;
        if (req) state_next = ACCESS;
      end
      ACCESS: begin
        stall = 1'b1;
        if (cnt == CNT_W'(WAIT)) begin
          complete = 1'b1;
          if (last) state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Captured request, wait counter and read result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend    <= '0;
      cnt     <= '0;
      addr_q  <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      busy_q <= (state_next == ACCESS);
      if (capture) begin
        pend    <= {memWE, mem4RE, mem3RE, mem2RE, mem1RE};
        addr_q  <= {addr4, addr3, addr2, addr1};
        waddr_q <= waddr;
        wdata_q <= wdata;
        cnt     <= '0;
      end else if (state == ACCESS) begin
        if (complete) begin
          pend <= pend & ~cur;
          cnt  <= '0;
          for (int k = 0; k < SLOTS; k++) begin
            if (cur[k]) rdata_q[k] <= ram[addr_q[k]];
          end
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

  // RAM contents survive reset; a write lands only when its access completes.
  always_ff @(posedge clk) begin
    if (ram_we) ram[waddr_q] <= wdata_q;
  end

  assign rdata1 = rdata_q[0];
  assign rdata2 = rdata_q[1];
  assign rdata3 = rdata_q[2];
  assign rdata4 = rdata_q[3];
  assign busy   = busy_q;

endmodule

// File: tb/tb_mem_resp.sv
// Scoreboard bench for mem_resp: driver pushes expected results from a
// behavioural RAM model; a monitor checks each stall/DONE sequence.
module tb_mem_resp;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 8;
  localparam int unsigned WT = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          we, re1, re2, re3, re4;
  logic [AW-1:0] waddr, a1, a2, a3, a4;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata1, rdata2, rdata3, rdata4;
  logic          stall, busy;
  logic [3:0][DW-1:0] rd_dut;

  always #5 clk = ~clk;

  mem_resp #(.DATA_W(DW), .ADDR_W(AW), .WAIT(WT)) dut (
    .clk(clk), .rst(rst), .memWE(we), .waddr(waddr), .wdata(wdata),
    .mem1RE(re1), .mem2RE(re2), .mem3RE(re3), .mem4RE(re4),
    .addr1(a1), .addr2(a2), .addr3(a3), .addr4(a4),
    .rdata1(rdata1), .rdata2(rdata2), .rdata3(rdata3), .rdata4(rdata4),
    .stall(stall), .busy(busy)
  );

  assign rd_dut = {rdata4, rdata3, rdata2, rdata1};

  typedef struct packed {
    logic [31:0]        cycles;
    logic [3:0][DW-1:0] rd;
  } exp_t;

  exp_t               q[$];
  logic [DW-1:0]      ram_m [int];
  logic [3:0][DW-1:0] rd_m;
  int                 total = 0;
  int                 bad   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Reads see the RAM as it was before this request's write.
  function automatic void model(input logic [4:0] m, input logic [3:0][AW-1:0] a,
                                input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    exp_t e;
    int   n = 0;
    for (int k = 0; k < 4; k++) begin
      if (m[k]) begin
        rd_m[k] = ram_m.exists(int'(a[k])) ? ram_m[int'(a[k])] : 'x;
        n++;
      end
    end
    if (m[4]) begin
      ram_m[int'(wa)] = wd;
      n++;
    end
    e.cycles = 32'(1 + n * (WT + 1));
    e.rd     = rd_m;
    q.push_back(e);
  endfunction

  function automatic logic [3:0][AW-1:0] ad(input logic [AW-1:0] x1, x2, x3, x4);
    return {x4, x3, x2, x1};
  endfunction

  task automatic drive(input logic [4:0] m, input logic [3:0][AW-1:0] a,
                       input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    {we, re4, re3, re2, re1} = m;
    {a4, a3, a2, a1} = a;
    waddr = wa;
    wdata = wd;
  endtask

  task automatic scramble_inputs();
    drive(5'($urandom), {AW'($urandom), AW'($urandom), AW'($urandom), AW'($urandom)},
          AW'($urandom), DW'($urandom));
  endtask

  // Returns at the negedge of the DONE cycle.
  task automatic wait_done(input bit scramble);
    int n = 0;
    @(negedge clk);
    while (stall !== 1'b0 && n < 200) begin
      if (scramble) scramble_inputs();
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("done_timeout", 32'(stall), 32'(0));
  endtask

  task automatic issue(input logic [4:0] m, input logic [3:0][AW-1:0] a,
                       input logic [AW-1:0] wa, input logic [DW-1:0] wd, input bit scramble);
    @(posedge clk); #1;
    drive(m, a, wa, wd);
    model(m, a, wa, wd);
    @(posedge clk);
    wait_done(scramble);
  endtask

  task automatic idle(input int n);
    @(posedge clk); #1;
    drive(5'b0, '0, '0, '0);
    repeat (n) begin
      @(negedge clk);
      check("idle_stall", 32'(stall), 32'(0));
      check("idle_busy", 32'(busy), 32'(0));
    end
  endtask

  // Monitor: count stall/busy cycles, and check results when stall drops.
  int   scnt = 0;
  int   bcnt = 0;
  exp_t em;
  always @(negedge clk) begin
    if (rst) begin
      scnt = 0;
      bcnt = 0;
    end else if (stall) begin
      scnt++;
      if (busy) bcnt++;
    end else if (scnt > 0) begin
      if (q.size() == 0) begin
        check("spurious_done", 32'(scnt), 32'(0));
      end else begin
        em = q.pop_front();
        check("stall_len", 32'(scnt), em.cycles);
        check("busy_len", 32'(bcnt), em.cycles - 32'(1));
        check("busy_done", 32'(busy), 32'(0));
        for (int k = 0; k < 4; k++)
          check($sformatf("rdata%0d", k + 1), 32'(rd_dut[k]), 32'(em.rd[k]));
      end
      scnt = 0;
      bcnt = 0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    drive(5'b0, '0, '0, '0);
    rd_m = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_stall", 32'(stall), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    for (int k = 0; k < 4; k++)
      check($sformatf("rst_rdata%0d", k + 1), 32'(rd_dut[k]), 32'(0));

    // Write then read back.
    issue(5'b10000, ad(8'h00, 8'h00, 8'h00, 8'h00), 8'h10, 16'hBEEF, 1'b0);
    issue(5'b00001, ad(8'h10, 8'h00, 8'h00, 8'h00), 8'h00, 16'h0000, 1'b0);

    // Preload and four reads at once.
    issue(5'b10000, '0, 8'h01, 16'h1111, 1'b0);
    issue(5'b10000, '0, 8'h02, 16'h2222, 1'b0);
    issue(5'b10000, '0, 8'h03, 16'h3333, 1'b0);
    issue(5'b10000, '0, 8'h04, 16'h4444, 1'b0);
    issue(5'b01111, ad(8'h01, 8'h02, 8'h03, 8'h04), 8'h00, 16'h0000, 1'b0);

    // Read and write the same address in one request.
    issue(5'b10000, '0, 8'h20, 16'h0AAA, 1'b0);
    issue(5'b10001, ad(8'h20, 8'h00, 8'h00, 8'h00), 8'h20, 16'h5555, 1'b0);
    issue(5'b00010, ad(8'h00, 8'h20, 8'h00, 8'h00), 8'h00, 16'h0000, 1'b0);

    // Strobes held through DONE: two identical back-to-back requests.
    @(posedge clk); #1;
    drive(5'b10011, ad(8'h01, 8'h02, 8'h00, 8'h00), 8'h02, 16'h7777);
    model(5'b10011, ad(8'h01, 8'h02, 8'h00, 8'h00), 8'h02, 16'h7777);
    model(5'b10011, ad(8'h01, 8'h02, 8'h00, 8'h00), 8'h02, 16'h7777);
    @(posedge clk);
    wait_done(1'b0);
    @(posedge clk);
    @(posedge clk);
    wait_done(1'b0);
    idle(2);

    // Reset in the second cycle of a four-read request.
    @(posedge clk); #1;
    drive(5'b01111, ad(8'h01, 8'h02, 8'h03, 8'h04), 8'h00, 16'h0000);
    @(posedge clk); #1;
    rst = 1'b1;
    drive(5'b0, '0, '0, '0);
    #1;
    check("midrst_stall", 32'(stall), 32'(0));
    check("midrst_busy", 32'(busy), 32'(0));
    for (int k = 0; k < 4; k++)
      check($sformatf("midrst_rdata%0d", k + 1), 32'(rd_dut[k]), 32'(0));
    rd_m = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    issue(5'b01111, ad(8'h01, 8'h02, 8'h03, 8'h04), 8'h00, 16'h0000, 1'b0);

    // Random traffic over a small fully-initialised address window.
    for (int i = 0; i < 16; i++)
      issue(5'b10000, '0, AW'(i), DW'($urandom), 1'b1);
    for (int i = 0; i < 60; i++) begin
      issue(5'($urandom_range(1, 31)),
            ad(AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15)),
               AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15))),
            AW'($urandom_range(0, 15)), DW'($urandom), 1'b1);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
    end

    idle(4);
    check("queue_empty", 32'(q.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_resp.md
Name: mem_resp

Overview:
- Memory responder on the far side of the control unit's memory strobes. The control unit drives memWE and mem1RE..mem4RE; this block answers them.
- Serves every strobed operand read and the result write through one single-port RAM with configurable wait states.
- Drives the control unit's stall input until all accesses of the current state have finished.

Parameters:
- DATA_W, 16, data word width.
- ADDR_W, 8, address width; RAM depth is 2**ADDR_W words.
- WAIT, 1, wait states per access (0..15); each access occupies WAIT+1 cycles.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- memWE  input  1  write request.
- waddr  input  ADDR_W  write address.
- wdata  input  DATA_W  write data.
- mem1RE, mem2RE, mem3RE, mem4RE  input  1 each  read requests for operand slots 1..4.
- addr1, addr2, addr3, addr4  input  ADDR_W each  read addresses for slots 1..4.
- rdata1, rdata2, rdata3, rdata4  output  DATA_W each  read results for slots 1..4.
- stall  output  1  high while a request is outstanding; goes to the control unit's stall input.
- busy  output  1  registered, high in ACCESS state (debug).

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE, rdata1..4=0, busy=0, pending mask=0, wait counter=0.
  - stall then follows only the IDLE equation below.
  - RAM contents are not reset.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - req = memWE | mem1RE | mem2RE | mem3RE | mem4RE.
  - stall = req, combinational in this state only.
  - If req: at the clock edge, capture pending mask {W,R4,R3,R2,R1}, all four addresses, waddr and wdata; clear the counter; go to ACCESS.
- ACCESS:
  - stall=1, busy=1.
  - Current access is the lowest set pending bit, in order R1, R2, R3, R4, then W (reads complete before the write).
  - Counter counts 0..WAIT. At count==WAIT the access completes:
    - a read loads the captured slot address's RAM word into that rdataK register;
    - a write stores the captured wdata at the captured waddr;
    - the bit is cleared and the counter is reset to 0.
  - If no bits remain after clearing, go to DONE; otherwise stay in ACCESS for the next access.
- DONE:
  - stall=0, busy=0, for exactly one cycle; then go to IDLE.
  - Request inputs are ignored in DONE. The control unit advances on this edge, so the next IDLE cycle sees only the next state's strobes.
- Latency for N strobed accesses: stall high for 1 + N*(WAIT+1) cycles, then low in DONE.
  - rdataK is valid from the cycle after its access completes and is held until overwritten by a later read of slot K.
  - Unstrobed slots keep their old rdata.
- Same address read and written in one request: the read returns the old data.
- Inputs may change while stall=1; only the captured copies are used.
- Address arithmetic: none. Addresses index the RAM directly, no wrap or offset logic.
- Reset mid-ACCESS: the pending operation is abandoned. A write not yet completed is not performed; a write that has already completed stays in RAM.

Test Plan:
- Reset, then idle with no strobes -> stall=0, busy=0, rdata1..4=0, state stays IDLE.
- WAIT=1, memWE with waddr=0x10, wdata=0xBEEF -> stall high 3 cycles, DONE 1 cycle with stall=0; later mem1RE with addr1=0x10 -> rdata1=0xBEEF after 3 stall cycles.
- Preload 0x01=0x1111, 0x02=0x2222, 0x03=0x3333, 0x04=0x4444; then all four REs together -> stall high 1+4*2=9 cycles; rdata1..4=0x1111, 0x2222, 0x3333, 0x4444 at DONE.
- mem1RE addr1=0x20 plus memWE waddr=0x20, wdata=0x5555, with 0x20 holding 0x0AAA -> rdata1=0x0AAA, then RAM[0x20]=0x5555; stall high 5 cycles.
- Strobes held high through DONE for two back-to-back identical requests -> two complete stall/DONE sequences, each of the same length; nothing is lost or duplicated within a request.
- rst asserted in the second cycle of a 4-read request -> stall and busy drop the same cycle, rdata1..4=0 immediately, and the next request is serviced normally.
